scram_ctrl_128b130b: RTL and testbench

- Per-lane sequencer for the Gen3 scrambler datapath (scram_data XOR LFSR feed).
- Tracks 128b/130b block framing on a byte stream at the 1 GHz symbol clock and classifies each block from its sync header and ordered-set identifier.
- Drives the per-symbol LFSR-advance and XOR-apply enables, the LFSR reseed (rst_mod) and the lane number.
- Sits between the DLL/framing logic and the scrambler; all outputs are registered, aligned with the forwarded byte.

---
 rtl/scram_ctrl_128b130b.sv | 162 ++++++++++++++++
 tb/tb_scram_ctrl_128b130b.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/scram_ctrl_128b130b.sv
// rtl/scram_ctrl_128b130b.sv - per-lane 128b/130b block framer and scrambler enable sequencer
module scram_ctrl_128b130b #(
    parameter int          BLK_SYMS   = 16,
    parameter logic [7:0]  SKP_ID     = 8'hAA,
    parameter logic [7:0]  EIEOS_ID   = 8'h00,
    parameter logic [7:0]  TS1_ID     = 8'h1E,
    parameter logic [7:0]  TS2_ID     = 8'h2D,
    parameter int          RST_CYCLES = 2
) (
    input  logic       clk_1G,
    input  logic       rst_1G,
    input  logic       ctrl_en,
    input  logic [1:0] lane_cfg,
    input  logic       sym_valid,
    input  logic [7:0] sym_in,
    input  logic       blk_start,
    input  logic [1:0] sync_hdr,
    input  logic       force_reseed,
    output logic [7:0] sym_out,
    output logic       sym_valid_out,
    output logic [1:0] en_scram,
    output logic       rst_mod,
    output logic [1:0] lanenum,
    output logic [3:0] sym_idx,
    output logic       hdr_err
);

    // Reseed pulse counter holds the remaining low cycles after the current one
    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [3:0] LAST_SYM = 4'(BLK_SYMS - 1);

    typedef enum logic [2:0] {
        IDLE,
        DATA,
        OS_SCR,
        OS_RAW,
        SKP
    } state_t;

    state_t        state;
    state_t        state_n;
    state_t        cls;
    logic [3:0]    cnt;
    logic [3:0]    cnt_n;
    logic          eieos;
    logic          eieos_n;
    logic          eieos_end;
    logic          eie_fire;
    logic          bad_hdr;
    logic [1:0]    en_n;
    logic [3:0]    idx_n;
    logic          err_n;
    logic          trig;
    logic          rst_mod_n;
    logic [RW-1:0] rst_left;
    logic [RW-1:0] rst_left_n;

    // Classify a block from its sync header and ordered-set identifier
    always_comb begin
        cls     = OS_RAW;
        bad_hdr = 1'b0;
        case (sync_hdr)
            2'b10: cls = DATA;
            2'b01: begin
                if (sym_in == SKP_ID)
                    cls = SKP;
                else if (sym_in == TS1_ID || sym_in == TS2_ID)
                    cls = OS_SCR;
                else
                    cls = OS_RAW;
            end
            default: bad_hdr = 1'b1;
        endcase
    end

    // Next framing state, per-symbol enables and reseed pulse decode
    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        eieos_n   = eieos;
        en_n      = 2'b00;
        idx_n     = sym_idx;
        err_n     = 1'b0;
        eieos_end = 1'b0;
        if (sym_valid) begin
            idx_n = 4'd0;
            if (!ctrl_en) begin
                state_n = IDLE;
                cnt_n   = 4'd0;
                eieos_n = 1'b0;
            end else if (blk_start) begin
                state_n = cls;
                cnt_n   = (LAST_SYM == 4'd0) ? 4'd0 : 4'd1;
                eieos_n = (sync_hdr == 2'b01) && (sym_in == EIEOS_ID);
                err_n   = bad_hdr || (cnt != 4'd0);
                case (cls)
                    DATA:    en_n = 2'b11;
                    SKP:     en_n = 2'b00;
                    default: en_n = 2'b10;
                endcase
            end else if (state == IDLE) begin
                cnt_n = 4'd0;
            end else if (cnt == 4'd0) begin
                // expected a block boundary but the header never came
                err_n   = 1'b1;
                state_n = IDLE;
                eieos_n = 1'b0;
            end else begin
                idx_n     = cnt;
                cnt_n     = (cnt == LAST_SYM) ? 4'd0 : cnt + 4'd1;
                eieos_end = (state == OS_RAW) && eieos && (cnt == LAST_SYM);
                case (state)
                    DATA, OS_SCR: en_n = 2'b11;
                    OS_RAW:       en_n = 2'b10;
                    default:      en_n = 2'b00;
                endcase
            end
        end
        trig       = eie_fire || force_reseed;
        rst_mod_n  = !(trig || (rst_left != '0));
        if (trig)
            rst_left_n = RW'(RST_CYCLES - 1);
        else if (rst_left != '0)
            rst_left_n = rst_left - 1'b1;
        else
            rst_left_n = '0;
    end

    // Framing FSM and registered outputs, all aligned with the forwarded byte
    always_ff @(posedge clk_1G) begin
        if (rst_1G) begin
            state         <= IDLE;
            cnt           <= 4'd0;
            eieos         <= 1'b0;
            eie_fire      <= 1'b0;
            rst_left      <= '0;
            sym_out       <= 8'd0;
            sym_valid_out <= 1'b0;
            en_scram      <= 2'b00;
            rst_mod       <= 1'b0;
            lanenum       <= lane_cfg;
            sym_idx       <= 4'd0;
            hdr_err       <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            eieos         <= eieos_n;
            // a coincident force_reseed already covers the EIEOS reseed
            eie_fire      <= eieos_end && !force_reseed;
            rst_left      <= rst_left_n;
            sym_out       <= sym_in;
            sym_valid_out <= sym_valid;
            en_scram      <= {en_n[1] && rst_mod_n, en_n[0]};
            rst_mod       <= rst_mod_n;
            sym_idx       <= idx_n;
            hdr_err       <= err_n;
            if (!rst_mod)
                lanenum <= lane_cfg;
        end
    end

endmodule

// File: tb/tb_scram_ctrl_128b130b.sv
// tb/tb_scram_ctrl_128b130b.sv - randomized self-checking bench for scram_ctrl_128b130b
`timescale 1ns/1ps
module tb_scram_ctrl_128b130b;

    logic       clk_1G = 1'b0;
    logic       rst_1G;
    logic       ctrl_en;
    logic [1:0] lane_cfg;
    logic       sym_valid;
    logic [7:0] sym_in;
    logic       blk_start;
    logic [1:0] sync_hdr;
    logic       force_reseed;
    logic [7:0] sym_out;
    logic       sym_valid_out;
    logic [1:0] en_scram;
    logic       rst_mod;
    logic [1:0] lanenum;
    logic [3:0] sym_idx;
    logic       hdr_err;

    int n_checks = 0;
    int n_fail   = 0;
    logic started = 1'b0;

    scram_ctrl_128b130b dut (
        .clk_1G(clk_1G), .rst_1G(rst_1G), .ctrl_en(ctrl_en), .lane_cfg(lane_cfg),
        .sym_valid(sym_valid), .sym_in(sym_in), .blk_start(blk_start), .sync_hdr(sync_hdr),
        .force_reseed(force_reseed), .sym_out(sym_out), .sym_valid_out(sym_valid_out),
        .en_scram(en_scram), .rst_mod(rst_mod), .lanenum(lanenum), .sym_idx(sym_idx),
        .hdr_err(hdr_err)
    );

    always #0.5 clk_1G = ~clk_1G;

    // block kinds of the reference model
    localparam int K_NONE = 0, K_DATA = 1, K_SCR = 2, K_RAW = 3, K_SKP = 4;

    typedef struct packed {
        logic [2:0] kind;
        logic [4:0] pos;     // symbols of the current block received so far
        logic       eie;
        logic       fire;    // EIEOS block just ended, reseed starts next
        logic [2:0] pulse;   // low cycles still owed on rst_mod
        logic [7:0] so;
        logic       vo;
        logic [1:0] en;
        logic       rm;
        logic [1:0] lane;
        logic [3:0] idx;
        logic       err;
    } ms_t;

    ms_t ms;

    function automatic logic [1:0] en_tbl(input int kind, input int pos);
        case (kind)
            K_DATA:  return 2'b11;
            K_SCR:   return (pos == 0) ? 2'b10 : 2'b11;
            K_RAW:   return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

    function automatic int classify(input logic [1:0] h, input logic [7:0] b);
        if (h == 2'b10) return K_DATA;
        if (h != 2'b01) return K_RAW;
        if (b == 8'hAA) return K_SKP;
        if (b == 8'h1E || b == 8'h2D) return K_SCR;
        return K_RAW;
    endfunction

    function automatic ms_t step(input ms_t s, input logic rst, input logic en_c,
                                 input logic [1:0] lane, input logic v, input logic bs,
                                 input logic [1:0] h, input logic [7:0] b, input logic fr);
        ms_t n;
        logic trig;
        n = s;
        if (rst) begin
            n = '0;
            n.lane = lane;
            return n;
        end
        n.so = b;
        n.vo = v;
        n.en = 2'b00;
        n.err = 1'b0;
        n.fire = 1'b0;
        trig = s.fire || fr;
        if (!s.rm) n.lane = lane;
        if (v) begin
            n.idx = 4'd0;
            if (!en_c) begin
                n.kind = 3'(K_NONE); n.pos = 5'd0; n.eie = 1'b0;
            end else if (bs) begin
                n.err  = (h == 2'b00) || (h == 2'b11) ||
                         (s.kind != 3'(K_NONE) && s.pos > 0 && s.pos < 16);
                n.kind = 3'(classify(h, b));
                n.pos  = 5'd1;
                n.eie  = (h == 2'b01) && (b == 8'h00);
                n.en   = en_tbl(int'(n.kind), 0);
            end else if (s.kind == 3'(K_NONE)) begin
                n.pos = 5'd0;
            end else if (s.pos == 16) begin
                n.err = 1'b1; n.kind = 3'(K_NONE); n.pos = 5'd0;
            end else begin
                n.idx = s.pos[3:0];
                n.en  = en_tbl(int'(s.kind), int'(s.pos));
                if (s.kind == 3'(K_RAW) && s.eie && s.pos == 15) n.fire = !fr;
                n.pos = s.pos + 5'd1;
            end
        end
        if (trig) n.pulse = 3'd2;
        else n.pulse = s.pulse;
        if (n.pulse != 0) begin
            n.rm = 1'b0;
            n.pulse = n.pulse - 3'd1;
        end else begin
            n.rm = 1'b1;
        end
        n.en[1] = n.en[1] & n.rm;
        return n;
    endfunction

    // reference model advances on every clock edge
    always @(posedge clk_1G)
        ms <= step(ms, rst_1G, ctrl_en, lane_cfg, sym_valid, blk_start, sync_hdr, sym_in, force_reseed);

    task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h at %0t", nm, got, exp, $time);
        end
    endtask

    // compare every output against the model mid-cycle
    always @(negedge clk_1G) begin
        if (started) begin
            chk("sym_out", 32'(sym_out), 32'(ms.so));
            chk("sym_valid_out", 32'(sym_valid_out), 32'(ms.vo));
            chk("en_scram", 32'(en_scram), 32'(ms.en));
            chk("rst_mod", 32'(rst_mod), 32'(ms.rm));
            chk("lanenum", 32'(lanenum), 32'(ms.lane));
            chk("sym_idx", 32'(sym_idx), 32'(ms.idx));
            chk("hdr_err", 32'(hdr_err), 32'(ms.err));
        end
    end

    task automatic sym(input logic v, input logic bs, input logic [1:0] h,
                       input logic [7:0] b, input logic fr);
        @(negedge clk_1G);
        sym_valid = v; blk_start = bs; sync_hdr = h; sym_in = b; force_reseed = fr;
    endtask

    task automatic peek();
        @(posedge clk_1G);
        #0.2;
    endtask

    task automatic body(input int n);
        for (int i = 0; i < n; i++) sym(1'b1, 1'b0, 2'b00, 8'($urandom), 1'b0);
    endtask

    initial begin
        int gpos;
        int r;
        logic v, bs, fr;
        logic [1:0] h;
        logic [7:0] b;
        rst_1G = 1'b1; ctrl_en = 1'b1; lane_cfg = 2'd2; sym_valid = 1'b0; sym_in = 8'd0;
        blk_start = 1'b0; sync_hdr = 2'b00; force_reseed = 1'b0;
        @(posedge clk_1G);
        started = 1'b1;
        repeat (3) sym(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        peek();
        chk("pin_reset_rst_mod", 32'(rst_mod), 32'd0);
        chk("pin_reset_en", 32'(en_scram), 32'd0);
        chk("pin_reset_lane", 32'(lanenum), 32'd2);
        rst_1G = 1'b0;
        sym(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        peek();
        chk("pin_release_rst_mod", 32'(rst_mod), 32'd1);

        // data block
        sym(1'b1, 1'b1, 2'b10, 8'h55, 1'b0); peek();
        chk("pin_data_en0", 32'(en_scram), 32'd3);
        chk("pin_data_idx0", 32'(sym_idx), 32'd0);
        body(15); peek();
        chk("pin_data_idx15", 32'(sym_idx), 32'd15);
        // TS1 ordered set
        sym(1'b1, 1'b1, 2'b01, 8'h1E, 1'b0); peek();
        chk("pin_ts1_en0", 32'(en_scram), 32'd2);
        body(1); peek();
        chk("pin_ts1_en1", 32'(en_scram), 32'd3);
        body(14);
        // SKP then data
        sym(1'b1, 1'b1, 2'b01, 8'hAA, 1'b0); peek();
        chk("pin_skp_en0", 32'(en_scram), 32'd0);
        body(15);
        sym(1'b1, 1'b1, 2'b10, 8'h12, 1'b0); peek();
        chk("pin_after_skp_en", 32'(en_scram), 32'd3);
        body(15);
        // EIEOS then data during the reseed pulse
        sym(1'b1, 1'b1, 2'b01, 8'h00, 1'b0); peek();
        chk("pin_eieos_en0", 32'(en_scram), 32'd2);
        body(15); peek();
        chk("pin_eieos_last_rst_mod", 32'(rst_mod), 32'd1);
        chk("pin_eieos_last_en", 32'(en_scram), 32'd2);
        sym(1'b1, 1'b1, 2'b10, 8'h34, 1'b0); peek();
        chk("pin_pulse1_rst_mod", 32'(rst_mod), 32'd0);
        chk("pin_pulse1_en", 32'(en_scram), 32'd1);
        body(1); peek();
        chk("pin_pulse2_rst_mod", 32'(rst_mod), 32'd0);
        chk("pin_pulse2_en", 32'(en_scram), 32'd1);
        body(1); peek();
        chk("pin_pulse_end_rst_mod", 32'(rst_mod), 32'd1);
        chk("pin_pulse_end_en", 32'(en_scram), 32'd3);
        body(13);
        // misaligned blk_start with bad header at symbol 7
        sym(1'b1, 1'b1, 2'b10, 8'h77, 1'b0);
        body(6);
        sym(1'b1, 1'b1, 2'b11, 8'h99, 1'b0); peek();
        chk("pin_mis_err", 32'(hdr_err), 32'd1);
        chk("pin_mis_idx", 32'(sym_idx), 32'd0);
        chk("pin_mis_en", 32'(en_scram), 32'd2);
        body(1); peek();
        chk("pin_mis_err_clear", 32'(hdr_err), 32'd0);
        chk("pin_mis_idx1", 32'(sym_idx), 32'd1);
        body(14);
        // stall at symbol 5
        sym(1'b1, 1'b1, 2'b10, 8'h5A, 1'b0);
        body(5); peek();
        chk("pin_stall_idx5", 32'(sym_idx), 32'd5);
        for (int i = 0; i < 3; i++) begin
            sym(1'b0, 1'b0, 2'b00, 8'h00, 1'b0); peek();
            chk("pin_stall_hold", 32'(sym_idx), 32'd5);
            chk("pin_stall_en", 32'(en_scram), 32'd0);
        end
        body(10); peek();
        chk("pin_stall_idx15", 32'(sym_idx), 32'd15);
        body(1); peek();
        chk("pin_boundary_err", 32'(hdr_err), 32'd1);
        chk("pin_boundary_en", 32'(en_scram), 32'd0);

        // randomized traffic
        gpos = 16;
        for (int c = 0; c < 3000; c++) begin
            if (c == 1500) rst_1G = 1'b1;
            if (c == 1503) rst_1G = 1'b0;
            ctrl_en = ($urandom_range(99) >= 3);
            if ($urandom_range(99) < 5) lane_cfg = 2'($urandom);
            v  = ($urandom_range(99) >= 10);
            fr = ($urandom_range(99) < 2);
            b  = 8'($urandom);
            h  = 2'($urandom);
            bs = 1'b0;
            if (v) begin
                if (gpos >= 16) bs = ($urandom_range(99) >= 4);
                else bs = ($urandom_range(99) < 2);
                if (bs) begin
                    r = int'($urandom_range(9));
                    if (r < 4) h = 2'b10;
                    else if (r < 9) h = 2'b01;
                    case ($urandom_range(4))
                        0: b = 8'hAA;
                        1: b = 8'h00;
                        2: b = 8'h1E;
                        3: b = 8'h2D;
                        default: b = 8'($urandom);
                    endcase
                    gpos = 1;
                end else begin
                    gpos++;
                end
            end
            sym(v, bs, h, b, fr);
        end
        sym(1'b0, 1'b0, 2'b00, 8'h00, 1'b0);
        repeat (4) @(negedge clk_1G);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
